sub_issue_wb: RTL
=================

Name: sub_issue_wb

Overview:
Operand-issue and writeback stage wrapped around the existing combinational N-bit ripple subtractor.
- Accepts a register-to-register subtract command over a valid/ready handshake.
- Reads both source operands from an internal register file and drives them to the subtractor.
- Captures sub_rd and bo one cycle later and writes the difference back to the destination register.
- Updates the borrow and zero status flags.
- Sits between the instruction decode logic (upstream) and the subtractor datapath (downstream/beside).

Parameters:
N, 16, operand/result width; must match the subtractor's N
NREG, 8, number of architectural registers
AW, $clog2(NREG), register address width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  subtract command present
cmd_ready  out  1  stage can accept a command
cmd_rs1  in  AW  minuend register index
cmd_rs2  in  AW  subtrahend register index
cmd_rd  in  AW  destination register index
cmd_bin  in  1  borrow-in for the operation
ld_valid  in  1  host register-file load strobe
ld_addr  in  AW  load index
ld_data  in  N  load value
rs1_reg  out  N  minuend to subtractor
rs2_reg  out  N  subtrahend to subtractor
bin  out  1  borrow-in to subtractor
sub_rd  in  N  difference from subtractor
bo  in  1  borrow-out from subtractor
done  out  1  one-cycle pulse: writeback completed
flag_borrow  out  1  bo of the last completed op
flag_zero  out  1  1 when the last written difference == 0
dbg_addr  in  AW  debug read index
dbg_data  out  N  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all NREG registers = 0.
  - rs1_reg/rs2_reg = 0, bin = 0.
  - done = 0, flag_borrow = 0, flag_zero = 0.
  - Reset asserted mid-EXEC aborts the op: no writeback, no done.
- FSM states:
  - IDLE: cmd_ready = !ld_valid.
    - On cmd_valid && cmd_ready: latch rs1_reg <= RF[cmd_rs1], rs2_reg <= RF[cmd_rs2], bin <= cmd_bin, rd_q <= cmd_rd; go to EXEC.
  - EXEC: cmd_ready = 0. Subtractor settles combinationally during this cycle.
    - At the end of the cycle: RF[rd_q] <= sub_rd, flag_borrow <= bo, flag_zero <= (sub_rd == 0), done <= 1; go to IDLE.
- Latency: handshake at edge T → operands on rs1_reg/rs2_reg through cycle T+1 → RF write at edge T+2, with done high in cycle T+2.
  - Throughput: one op per 2 cycles.
  - cmd_ready is high in the done cycle, so a back-to-back command accepted there reads the already-updated RF (no hazard, no forwarding needed).
- Operand outputs hold their values outside EXEC; they are not cleared on return to IDLE.
- Load port:
  - Honoured only in IDLE. Writes RF[ld_addr] <= ld_data at the edge.
  - ld_valid in IDLE forces cmd_ready = 0, so load has priority over a command in the same cycle.
  - ld_valid during EXEC is ignored and dropped (host must check cmd_ready/state).
- Aliasing:
  - rs1 == rs2 gives difference 0 (with bin=0).
  - rd equal to a source register is legal; sources were latched at issue.
- Arithmetic: wrap-around modulo 2^N; a borrow is reported via flag_borrow, never trapped. Flags change only on done.
- dbg_data is a pure combinational read; it reflects writes from the following cycle onward.
- cmd_* fields are sampled only on the handshake edge and may change freely otherwise.

Decomposition:
- Shared package m_cpu_pkg:
  - constants N_DEF=16, NREG_DEF=8.
  - typedef enum logic {IDLE, EXEC} sub_st_e.
  - typedef struct {rs1, rs2, rd, bin} sub_cmd_t.
- One sub-module: sub_regfile (NREG x N, two async read ports, one sync write port, async active-low clear). Writes are muxed from the load port and the writeback path.
- The subtractor itself remains external and is connected at the integration level.

Test Plan:
1. Reset → RF all 0, flags 0, done 0, cmd_ready 1. Assert rst_n=0 during EXEC → no RF write, no done.
2. Load R1=0x0050, R2=0x0030; cmd rs1=1, rs2=2, rd=3, bin=0 → rs1_reg=0x0050 and rs2_reg=0x0030 in T+1; R3=0x0020, done at T+2, flag_borrow=0, flag_zero=0.
3. R1=0x0010, R2=0x0020, rd=4 → R4=0xFFF0, flag_borrow=1. Then R1-R1 with bin=0 → 0x0000, flag_zero=1, flag_borrow=0.
4. Borrow-in: R1=0x0005, R2=0x0005, bin=1 → 0xFFFF, flag_borrow=1.
5. Back-to-back: cmd A writes R3, cmd B (reads R3) accepted in A's done cycle → B sees the new R3; done pulses at T+2 and T+4.
6. ld_valid and cmd_valid both high in IDLE → load written, cmd_ready=0, command accepted the next cycle. ld_valid during EXEC → RF unchanged.

Source files
------------

// File: rtl/m_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m_cpu_pkg
// Purpose  : Shared types and default sizes for the subtract issue/writeback
//            stage: FSM state encoding and the decoded subtract command.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package m_cpu_pkg;

  localparam int N_DEF    = 16;
  localparam int NREG_DEF = 8;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } sub_st_e;

  // Decoded register-to-register subtract command (default-sized fields).
  typedef struct packed {
    logic [AW_DEF-1:0] rs1;
    logic [AW_DEF-1:0] rs2;
    logic [AW_DEF-1:0] rd;
    logic              bin;
  } sub_cmd_t;

endpackage
`default_nettype wire

// File: rtl/sub_regfile.sv
`default_nettype none
// ============================================================================
// Module   : sub_regfile
// Purpose  : NREG x N architectural register file. Two asynchronous operand
//            read ports, one asynchronous debug read port, one synchronous
//            write port, asynchronous active-low clear of every entry.
// Ports    : clk, rst_n          - clock / async active-low clear
//            we, waddr, wdata    - synchronous write port
//            raddr_a / rdata_a   - operand read port A
//            raddr_b / rdata_b   - operand read port B
//            raddr_dbg/rdata_dbg - debug read port
// Revision : 1.0 - initial release
// ============================================================================
module sub_regfile #(
  parameter int N    = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b,
  input  logic [AW-1:0] raddr_dbg,
  output logic [N-1:0]  rdata_dbg
);

  logic [N-1:0] mem [NREG];

  // One flop bank per entry so each gets its own clear and write decode.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[i] <= '0;
      end else if (we && (waddr == AW'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  assign rdata_a   = mem[raddr_a];
  assign rdata_b   = mem[raddr_b];
  assign rdata_dbg = mem[raddr_dbg];

endmodule
`default_nettype wire

// File: rtl/sub_issue_wb.sv
`default_nettype none
// ============================================================================
// Module   : sub_issue_wb
// Purpose  : Operand-issue and writeback stage around an external
//            combinational N-bit subtractor. Accepts a subtract command,
//            drives the source operands for one EXEC cycle, then writes the
//            difference back and updates borrow/zero flags.
// Ports    : clk, rst_n                         - clock / async active-low reset
//            cmd_valid/ready, cmd_rs1/rs2/rd/bin - command handshake
//            ld_valid, ld_addr, ld_data          - host register load (IDLE only)
//            rs1_reg, rs2_reg, bin               - operands to subtractor
//            sub_rd, bo                          - result from subtractor
//            done, flag_borrow, flag_zero        - completion pulse and status
//            dbg_addr, dbg_data                  - combinational debug read
// Revision : 1.0 - initial release
// ============================================================================
module sub_issue_wb
  import m_cpu_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [AW-1:0] cmd_rd,
  input  logic          cmd_bin,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  output logic [N-1:0]  rs1_reg,
  output logic [N-1:0]  rs2_reg,
  output logic          bin,
  input  logic [N-1:0]  sub_rd,
  input  logic          bo,
  output logic          done,
  output logic          flag_borrow,
  output logic          flag_zero,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  sub_st_e       state, state_nx;
  logic [AW-1:0] rd_q;
  logic [N-1:0]  rf_rdata_a, rf_rdata_b;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [N-1:0]  rf_wdata;
  logic          accept;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state / handshake. A host load in IDLE blocks the command.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !ld_valid;
        if (cmd_valid && !ld_valid) state_nx = EXEC;
      end
      EXEC: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  // --------------------------------------------------------------------------
  // Register-file write mux: writeback in EXEC, host load in IDLE. Loads that
  // arrive during EXEC are dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state == EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = sub_rd;
    end else if (ld_valid) begin
      rf_we    = 1'b1;
    end
  end

  sub_regfile #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (cmd_rs1),
    .rdata_a   (rf_rdata_a),
    .raddr_b   (cmd_rs2),
    .rdata_b   (rf_rdata_b),
    .raddr_dbg (dbg_addr),
    .rdata_dbg (dbg_data)
  );

  // --------------------------------------------------------------------------
  // Issue / writeback datapath. Operands are latched at issue and held until
  // the next issue, so rd may alias a source without a hazard.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      bin         <= 1'b0;
      rd_q        <= '0;
      done        <= 1'b0;
      flag_borrow <= 1'b0;
      flag_zero   <= 1'b0;
    end else begin
      done <= (state == EXEC);
      if (accept) begin
        rs1_reg <= rf_rdata_a;
        rs2_reg <= rf_rdata_b;
        bin     <= cmd_bin;
        rd_q    <= cmd_rd;
      end
      if (state == EXEC) begin
        flag_borrow <= bo;
        flag_zero   <= (sub_rd == '0);
      end
    end
  end

endmodule
`default_nettype wire
